// File: rtl/bmu_search.sv
// -----------------------------------------------------------------------------
// bmu_search
//
// Best-matching-unit search for the SOFM datapath. A sweep starts on i_start in
// IDLE. It then takes one finished L1 distance per accepted i_valid, for
// neurons 0..N_NEURON-1 in index order. The stage keeps the running minimum and
// the index where it occurred. After the last neuron it raises o_done for
// exactly one cycle, and the winner outputs are final in that cycle.
//
// Handshake: i_valid has no back-pressure. It is honoured only in SCAN. The
// stage always accepts in SCAN, so a sample is consumed on every clock edge
// that sees i_valid=1 while o_busy=1. i_start is honoured only in IDLE.
// i_start and i_valid together in IDLE start the sweep and drop the sample.
//
// Optional feature: define BMU_SECOND_EN to also track the runner-up, which is
// driven on o_idx2 / o_dis2. Without the macro those ports do not exist.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a sweep (IDLE only)
//   i_valid      i_dis holds a completed neuron distance this cycle
//   i_dis        distance of the current neuron
//   o_busy       high in SCAN
//   o_done       one-cycle pulse, winner outputs final
//   o_win_idx    index of the minimum-distance neuron
//   o_win_dis    minimum distance
//   o_idx2       runner-up index     (BMU_SECOND_EN only)
//   o_dis2       runner-up distance  (BMU_SECOND_EN only)
//   o_dbg_state  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// -----------------------------------------------------------------------------
module bmu_search #(
  parameter int N_NEURON = 64,
  parameter int IDX_W    = 6,
  parameter int DIS_W    = 26
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [DIS_W-1:0] i_dis,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_win_idx,
  output logic [DIS_W-1:0] o_win_dis,
`ifdef BMU_SECOND_EN
  output logic [IDX_W-1:0] o_idx2,
  output logic [DIS_W-1:0] o_dis2,
`endif
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The counter is one bit wider than the index. With N_NEURON = 2^IDX_W, the
  // last neuron's count still fits without wrapping.
  localparam logic [IDX_W:0] LastCnt = (IDX_W+1)'(N_NEURON - 1);

  state_e           state_q, state_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [DIS_W-1:0] win_dis_q, win_dis_d;
`ifdef BMU_SECOND_EN
  logic [IDX_W-1:0] idx2_q, idx2_d;
  logic [DIS_W-1:0] dis2_q, dis2_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_idx_d = win_idx_q;
    win_dis_d = win_dis_q;
`ifdef BMU_SECOND_EN
    idx2_d    = idx2_q;
    dis2_d    = dis2_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // An all-ones distance is the "no candidate yet" seed. An all-max
          // sample can never beat it, so such a sweep reports index 0.
          cnt_d     = '0;
          win_idx_d = '0;
          win_dis_d = '1;
`ifdef BMU_SECOND_EN
          idx2_d    = '0;
          dis2_d    = '1;
`endif
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (i_valid) begin
          // The compare is strict, so on a tie the earlier (lower) index is kept.
          if (i_dis < win_dis_q) begin
            win_dis_d = i_dis;
            win_idx_d = cnt_q[IDX_W-1:0];
`ifdef BMU_SECOND_EN
            idx2_d    = win_idx_q;
            dis2_d    = win_dis_q;
          end else if (i_dis < dis2_q) begin
            idx2_d    = cnt_q[IDX_W-1:0];
            dis2_d    = i_dis;
`endif
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_idx_q <= '0;
      win_dis_q <= '0;
`ifdef BMU_SECOND_EN
      idx2_q    <= '0;
      dis2_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_idx_q <= win_idx_d;
      win_dis_q <= win_dis_d;
`ifdef BMU_SECOND_EN
      idx2_q    <= idx2_d;
      dis2_q    <= dis2_d;
`endif
    end
  end

  assign o_busy      = (state_q == S_SCAN);
  assign o_done      = (state_q == S_DONE);
  assign o_win_idx   = win_idx_q;
  assign o_win_dis   = win_dis_q;
`ifdef BMU_SECOND_EN
  assign o_idx2      = idx2_q;
  assign o_dis2      = dis2_q;
`endif
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bmu_search.sv
// -----------------------------------------------------------------------------
// tb_bmu_search
//
// Bench for bmu_search with N_NEURON = 4. Each sweep computes its expected
// winner from a small reference model and pushes the result into a queue. The
// model takes the lowest-index minimum; the runner-up is the next entry in the
// stable (distance, index) order. A monitor pops and compares on every o_done
// pulse. Directed sweeps are followed by randomized sweeps with gaps and stray
// inputs.
// -----------------------------------------------------------------------------
module tb_bmu_search;

  localparam int N_NEURON = 4;
  localparam int IDX_W    = 6;
  localparam int DIS_W    = 26;
  localparam int W        = IDX_W + DIS_W;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic             i_valid;
  logic [DIS_W-1:0] i_dis;
  logic             o_busy;
  logic             o_done;
  logic [IDX_W-1:0] o_win_idx;
  logic [DIS_W-1:0] o_win_dis;
`ifdef BMU_SECOND_EN
  logic [IDX_W-1:0] o_idx2;
  logic [DIS_W-1:0] o_dis2;
`endif
  logic [1:0]       o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp2_q[$];
  logic [DIS_W-1:0] stim[N_NEURON];

  bmu_search #(
    .N_NEURON(N_NEURON),
    .IDX_W   (IDX_W),
    .DIS_W   (DIS_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_dis      (i_dis),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_win_idx  (o_win_idx),
    .o_win_dis  (o_win_dis),
`ifdef BMU_SECOND_EN
    .o_idx2     (o_idx2),
    .o_dis2     (o_dis2),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: winner = smallest distance, lowest index on ties. Runner-up =
  // the next smallest in stable order. When the runner-up distance is all-ones
  // it is the untouched seed, so its index reads 0.
  task automatic ref_model(output logic [W-1:0] win, output logic [W-1:0] run);
    int bi;
    int si;
    bi = 0;
    for (int i = 1; i < N_NEURON; i++)
      if (stim[i] < stim[bi]) bi = i;
    si = -1;
    for (int i = 0; i < N_NEURON; i++)
      if (i != bi && (si < 0 || stim[i] < stim[si])) si = i;
    win = {IDX_W'(bi), stim[bi]};
    if (si < 0 || stim[si] == '1) run = {IDX_W'(0), {DIS_W{1'b1}}};
    else                          run = {IDX_W'(si), stim[si]};
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: o_done with no sweep pending");
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] e2;
        e  = exp_q.pop_front();
        e2 = exp2_q.pop_front();
        chk("win_idx", 64'(o_win_idx), 64'(e[W-1:DIS_W]));
        chk("win_dis", 64'(o_win_dis), 64'(e[DIS_W-1:0]));
`ifdef BMU_SECOND_EN
        chk("idx2", 64'(o_idx2), 64'(e2[W-1:DIS_W]));
        chk("dis2", 64'(o_dis2), 64'(e2[DIS_W-1:0]));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_sweep(input int gap_min, input int gap_max, input bit stray);
    logic [W-1:0] w;
    logic [W-1:0] r;
    ref_model(w, r);
    exp_q.push_back(w);
    exp2_q.push_back(r);
    if (stray) begin
      // A valid pulse in IDLE must be ignored; a zero would otherwise win.
      i_valid = 1'b1;
      i_dis   = '0;
      step();
    end
    i_start = 1'b1;
    i_valid = stray;
    i_dis   = '0;
    step();
    i_start = 1'b0;
    i_valid = 1'b0;
    chk("busy_scan", 64'(o_busy), 64'd1);
    for (int i = 0; i < N_NEURON; i++) begin
      int gap;
      gap = $urandom_range(gap_max, gap_min);
      repeat (gap) begin
        i_start = stray ? 1'($urandom_range(1, 0)) : 1'b0;
        i_valid = 1'b0;
        i_dis   = DIS_W'($urandom);
        step();
      end
      i_start = stray;
      i_valid = 1'b1;
      i_dis   = stim[i];
      step();
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    chk("done_latency", 64'(o_done), 64'd1);
    chk("busy_in_done", 64'(o_busy), 64'd0);
    step();
    chk("done_fall", 64'(o_done), 64'd0);
  endtask

  task automatic set4(input logic [DIS_W-1:0] a, input logic [DIS_W-1:0] b,
                      input logic [DIS_W-1:0] c, input logic [DIS_W-1:0] d);
    stim[0] = a;
    stim[1] = b;
    stim[2] = c;
    stim[3] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_done"},  64'(o_done), 64'd0);
    chk({tag, "_idx"},   64'(o_win_idx), 64'd0);
    chk({tag, "_dis"},   64'(o_win_dis), 64'd0);
    chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
`ifdef BMU_SECOND_EN
    chk({tag, "_idx2"},  64'(o_idx2), 64'd0);
    chk({tag, "_dis2"},  64'(o_dis2), 64'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_dis   = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset in the middle of a sweep.
    step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_dis   = 26'd9;
    step();
    i_valid = 1'b0;
    chk("mid_busy", 64'(o_busy), 64'd1);
    chk("mid_running_min", 64'(o_win_dis), 64'd9);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    set4(26'd40, 26'd12, 26'd33, 26'd25);
    run_sweep(0, 0, 1'b0);
    set4(26'd7, 26'd7, 26'd3, 26'd3);
    run_sweep(2, 2, 1'b0);
    set4(26'd40, 26'd12, 26'd33, 26'd25);
    run_sweep(1, 2, 1'b1);
    set4('1, '1, '1, '1);
    run_sweep(0, 0, 1'b0);
    set4(26'd5, 26'd9, 26'd2, 26'd8);
    run_sweep(0, 1, 1'b0);
    set4('1, 26'd5, '1, '1);
    run_sweep(0, 0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N_NEURON; i++) begin
        case ($urandom_range(3, 0))
          0:       stim[i] = DIS_W'($urandom);
          1:       stim[i] = '1;
          default: stim[i] = DIS_W'($urandom_range(7, 0));
        endcase
      end
      run_sweep(0, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    repeat (3) step();
    chk("pending_sweeps", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
